passcode_lock: RTL and testbench
================================

# passcode_lock

Keypad passcode controller for the 6-digit keypad/display board. It consumes the debounced single-cycle key events (`press_valid`, `scan_code`) from the scan/debounce stage and runs an entry/compare/lockout state machine. It produces the 24-bit `display_code` word for the existing 6-way digit mux, plus `unlocked` and `locked_out` status outputs. It replaces the plain shift buffer when the board runs as a door-lock demo.

## Interface
- `CODE_LEN`, 4: passcode length in digits, legal range 1..6.
- `PASSCODE`, 16'h1234: BCD passcode, width 4*CODE_LEN, most significant digit entered first.
- `MAX_TRIES`, 3: failed attempts allowed before lockout, range 1..9.
- `ENTRY_TIMEOUT`, 4096: idle cycles in ENTRY before the partial entry is abandoned.
- `OPEN_TICKS`, 8192: cycles spent in OPEN.
- `FAIL_TICKS`, 2048: cycles spent in FAIL.
- `LOCK_TICKS`, 32768: cycles spent in LOCKOUT.
- `clk` input 1: scan clock (the divided `clk_sel` domain); only clock.
- `rst` input 1: asynchronous, active-high reset.
- `key_valid` input 1: one-cycle key event strobe.
- `key_code` input 4: BCD digit; sampled only when `key_valid`=1.
- `display_code` output 24: six nibbles; [23:20] is the leftmost digit; 4'hF means blank.
- `unlocked` output 1: high only in OPEN.
- `locked_out` output 1: high only in LOCKOUT.
- `tries_left` output 4: remaining attempts, binary 0..MAX_TRIES.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- Accepted key: `key_valid`=1 and `key_code`<=9. Codes 10..15 are ignored in every state.
- IDLE:
  - Accepted key loads the entry register with that digit and sets digit count to 1.
  - Next state is ENTRY, or CHECK if CODE_LEN=1.
- ENTRY:
  - Accepted key shifts the entry left: {entry[4*CODE_LEN-5:0], key_code}. Count increments.
  - Any accepted key restarts the timeout timer.
  - When the count reaches CODE_LEN, next state is CHECK.
  - Timer expiry returns to IDLE, clears the entry, and does not count as a failure.
- CHECK: lasts exactly one cycle.
  - entry==PASSCODE: go to OPEN and reload `tries_left` to MAX_TRIES.
  - Otherwise: decrement `tries_left` and go to FAIL.
- OPEN: held for OPEN_TICKS cycles, then IDLE.
- FAIL: held for FAIL_TICKS cycles, then IDLE if `tries_left`>0, else LOCKOUT.
- LOCKOUT: held for LOCK_TICKS cycles, then IDLE with `tries_left`=MAX_TRIES.
- Keys arriving in CHECK, OPEN, FAIL or LOCKOUT are discarded. They are not queued.
- Display contents:
  - IDLE: 24'hFFFFFF.
  - ENTRY: entered digits right-aligned, unused positions 4'hF.
  - CHECK: same as ENTRY.
  - OPEN: 24'h000000.
  - FAIL: 24'hFFFFF followed by the `tries_left` nibble (already decremented).
  - LOCKOUT: 24'h888888.
- Entry register and digit count clear on every entry into IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `display_code`=24'hFFFFFF.
  - `unlocked`=0, `locked_out`=0.
  - `tries_left`=MAX_TRIES.
  - Entry and timer cleared.
- All outputs are registered. They update on the clk edge following the cause; no combinational path runs from `key_valid` to any output.
- The key that completes the code appears on `display_code` one cycle after its strobe. This is the CHECK cycle.
- `unlocked` or FAIL display asserts two cycles after the final strobe.
- Timer:
  - One shared down-counter, width $clog2 of the largest tick parameter.
  - Loaded on state entry and counts to 0.
  - The state changes on the cycle after the counter reads 0, so each state lasts exactly its *_TICKS cycles.
- Simultaneous events in ENTRY: an accepted key on the same cycle the timeout expires wins. The key is taken and the timer reloads.
- `rst` asserted mid-operation forces reset values immediately, asynchronously, in any state.

## Structure
- Shared package `lock_pkg`:
  - State enum `lock_state_t`.
  - Constants `DIGIT_BLANK`=4'hF, `DISP_BLANK`=24'hFFFFFF, `DISP_OPEN`=24'h000000, `DISP_LOCK`=24'h888888.
- One sub-module, `tick_timer`: loadable down-counter with a `load` strobe, `load_value` and a `zero` flag. Everything else lives in the top.

## Test plan
- Sim parameters: CODE_LEN=4, PASSCODE=16'h1234, MAX_TRIES=3, all tick parameters = 8.
- After reset: `display_code`=24'hFFFFFF and `tries_left`=3. Send keys 1,2,3,4 → display 24'hFF1234, then `unlocked`=1 for exactly 8 cycles, then back to IDLE.
- Send 1,2,3,5 → FAIL with display 24'hFFFFF2 for 8 cycles. Then 9,9,9,9 → display 24'hFFFFF1. Then 0,0,0,0 → 24'hFFFFF0, then `locked_out`=1 for 8 cycles and `tries_left`=3 afterwards.
- Send 1,2, then wait 8 idle cycles → IDLE, display 24'hFFFFFF, `tries_left` unchanged at 3.
- `key_code`=4'hB strobes mixed into the entry 1,B,2,3,4 → B ignored, unlock succeeds. Keys pressed during OPEN do not appear after the return to IDLE.
- Assert `rst` in the middle of LOCKOUT and in the middle of ENTRY → all outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/passcode_lock_pkg.sv
// Shared types and display constants for the keypad passcode lock.
// Imported by the lock controller and by its testbench.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        FAIL,
        LOCKOUT
    } lock_state_t;

    localparam logic [3:0]  DIGIT_BLANK = 4'hF;
    localparam logic [23:0] DISP_BLANK  = 24'hFFFFFF;
    localparam logic [23:0] DISP_OPEN   = 24'h000000;
    localparam logic [23:0] DISP_LOCK   = 24'h888888;

    // Only BCD digits count as key presses; 10..15 are dropped everywhere.
    function automatic logic key_accepted(input logic valid, input logic [3:0] code);
        return valid && (code <= 4'd9);
    endfunction

endpackage

// File: rtl/passcode_lock_if.sv
// Key-event and status bundle between the keypad front end and the lock.
// master = keypad/scan side, slave = lock controller.
interface passcode_lock_if;

    logic        key_valid;
    logic [3:0]  key_code;
    logic [23:0] display_code;
    logic        unlocked;
    logic        locked_out;
    logic [3:0]  tries_left;

    modport master (
        output key_valid,
        output key_code,
        input  display_code,
        input  unlocked,
        input  locked_out,
        input  tries_left
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output display_code,
        output unlocked,
        output locked_out,
        output tries_left
    );

endinterface

// File: rtl/passcode_lock_tick_timer.sv
// Loadable down-counter that stops at zero; shared by every timed state
// of the lock controller.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/passcode_lock.sv
// Keypad passcode controller: entry/compare/lockout FSM driving the
// six-digit display word and lock status, all outputs registered.
module passcode_lock
    import lock_pkg::*;
#(
    parameter int                    CODE_LEN      = 4,
    parameter logic [4*CODE_LEN-1:0] PASSCODE      = 16'h1234,
    parameter int                    MAX_TRIES     = 3,
    parameter int                    ENTRY_TIMEOUT = 4096,
    parameter int                    OPEN_TICKS    = 8192,
    parameter int                    FAIL_TICKS    = 2048,
    parameter int                    LOCK_TICKS    = 32768
) (
    input  logic            clk,
    input  logic            rst,
    passcode_lock_if.slave  bus
);

    localparam int EW      = 4 * CODE_LEN;
    localparam int MAX_AB  = (ENTRY_TIMEOUT > OPEN_TICKS) ? ENTRY_TIMEOUT : OPEN_TICKS;
    localparam int MAX_CD  = (FAIL_TICKS > LOCK_TICKS) ? FAIL_TICKS : LOCK_TICKS;
    localparam int MAX_TCK = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = (MAX_TCK > 1) ? $clog2(MAX_TCK) : 1;

    // Loading TICKS-1 makes each timed state last exactly TICKS cycles.
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] FAIL_LOAD  = TW'(FAIL_TICKS - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_TICKS - 1);
    localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [2:0]    LEN        = 3'(CODE_LEN);

    lock_state_t    state_q, state_d;
    logic [EW-1:0]  entry_q, entry_d;
    logic [2:0]     count_q, count_d;
    logic [3:0]     tries_q, tries_d;
    logic [23:0]    display_q, display_d;
    logic           unlocked_q, unlocked_d;
    logic           locked_q, locked_d;
    logic           key_ok;
    logic           timer_load;
    logic [TW-1:0]  timer_value;
    logic           timer_zero;
    logic [23:0]    entry_ext;

    assign key_ok = key_accepted(bus.key_valid, bus.key_code);

    tick_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        count_d    = count_q;
        tries_d    = tries_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_ok) begin
                    entry_d = EW'(bus.key_code);
                    count_d = 3'd1;
                    state_d = (CODE_LEN == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                // A key on the expiry cycle wins over the timeout.
                if (key_ok) begin
                    entry_d = (entry_q << 4) | EW'(bus.key_code);
                    count_d = count_q + 3'd1;
                    if (count_d == LEN) begin
                        state_d = CHECK;
                    end else begin
                        timer_load = 1'b1;
                    end
                end else if (timer_zero) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (entry_q == PASSCODE) begin
                    state_d = OPEN;
                    tries_d = TRIES_INIT;
                end else begin
                    state_d = FAIL;
                    tries_d = tries_q - 4'd1;
                end
            end
            OPEN: begin
                if (timer_zero) state_d = IDLE;
            end
            FAIL: begin
                if (timer_zero) state_d = (tries_q != 4'd0) ? IDLE : LOCKOUT;
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    state_d = IDLE;
                    tries_d = TRIES_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) timer_load = 1'b1;
        if (state_d == IDLE && state_q != IDLE) begin
            entry_d = '0;
            count_d = '0;
        end
    end

    always_comb begin
        timer_value = '0;
        case (state_d)
            ENTRY:   timer_value = ENTRY_LOAD;
            OPEN:    timer_value = OPEN_LOAD;
            FAIL:    timer_value = FAIL_LOAD;
            LOCKOUT: timer_value = LOCK_LOAD;
            default: timer_value = '0;
        endcase
    end

    assign entry_ext = 24'(entry_d);

    // Outputs are computed from next-state values so they register on the same edge.
    always_comb begin
        display_d  = DISP_BLANK;
        unlocked_d = (state_d == OPEN);
        locked_d   = (state_d == LOCKOUT);
        case (state_d)
            ENTRY, CHECK: begin
                for (int i = 0; i < 6; i++) begin
                    display_d[4*i +: 4] = (3'(i) < count_d) ? entry_ext[4*i +: 4] : DIGIT_BLANK;
                end
            end
            OPEN:    display_d = DISP_OPEN;
            FAIL:    display_d = {20'hFFFFF, tries_d};
            LOCKOUT: display_d = DISP_LOCK;
            default: display_d = DISP_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            entry_q    <= '0;
            count_q    <= '0;
            tries_q    <= TRIES_INIT;
            display_q  <= DISP_BLANK;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            count_q    <= count_d;
            tries_q    <= tries_d;
            display_q  <= display_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.display_code = display_q;
    assign bus.unlocked     = unlocked_q;
    assign bus.locked_out   = locked_q;
    assign bus.tries_left   = tries_q;

endmodule

// File: tb/tb_passcode_lock.sv
// Directed self-checking bench for passcode_lock with all tick lengths at 8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_passcode_lock;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    passcode_lock_if bus ();

    passcode_lock #(
        .CODE_LEN      (4),
        .PASSCODE      (16'h1234),
        .MAX_TRIES     (3),
        .ENTRY_TIMEOUT (8),
        .OPEN_TICKS    (8),
        .FAIL_TICKS    (8),
        .LOCK_TICKS    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle strobe; returns on the falling edge right after the capturing edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        #12;
        checks++;
        if (bus.display_code !== 24'hFFFFFF) begin
            failures++;
            $display("[TB] FAIL reset_display: got %h expected %h", bus.display_code, 24'hFFFFFF);
        end
        checks++;
        if (bus.tries_left !== 4'd3) begin
            failures++;
            $display("[TB] FAIL reset_tries: got %0d expected 3", bus.tries_left);
        end
        checks++;
        if (bus.unlocked !== 1'b0 || bus.locked_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status: got unlocked=%b locked_out=%b expected 0 0", bus.unlocked, bus.locked_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unlock();
        int open_cnt;
        press(4'd1);
        checks++;
        if (bus.display_code !== 24'hFFFFF1) begin
            failures++;
            $display("[TB] FAIL unlock_digit1: got %h expected %h", bus.display_code, 24'hFFFFF1);
        end
        press(4'd2);
        checks++;
        if (bus.display_code !== 24'hFFFF12) begin
            failures++;
            $display("[TB] FAIL unlock_digit2: got %h expected %h", bus.display_code, 24'hFFFF12);
        end
        press(4'd3);
        press(4'd4);
        checks++;
        if (bus.display_code !== 24'hFF1234 || bus.unlocked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL unlock_check_cycle: got %h/%b expected %h/0", bus.display_code, bus.unlocked, 24'hFF1234);
        end
        @(negedge clk);
        checks++;
        if (bus.unlocked !== 1'b1 || bus.display_code !== 24'h000000) begin
            failures++;
            $display("[TB] FAIL unlock_open_start: got %b/%h expected 1/%h", bus.unlocked, bus.display_code, 24'h000000);
        end
        open_cnt = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.unlocked === 1'b1) open_cnt++;
        end
        checks++;
        if (open_cnt != 8) begin
            failures++;
            $display("[TB] FAIL unlock_open_len: got %0d expected 8", open_cnt);
        end
        checks++;
        if (bus.display_code !== 24'hFFFFFF || bus.tries_left !== 4'd3) begin
            failures++;
            $display("[TB] FAIL unlock_back_idle: got %h/%0d expected %h/3", bus.display_code, bus.tries_left, 24'hFFFFFF);
        end
    endtask

    task automatic test_fail_lockout();
        int fail_cnt;
        int lock_cnt;
        press(4'd1); press(4'd2); press(4'd3); press(4'd5);
        checks++;
        if (bus.display_code !== 24'hFF1235) begin
            failures++;
            $display("[TB] FAIL fail1_check_cycle: got %h expected %h", bus.display_code, 24'hFF1235);
        end
        fail_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.display_code === 24'hFFFFF2) fail_cnt++;
        end
        checks++;
        if (fail_cnt != 8) begin
            failures++;
            $display("[TB] FAIL fail1_len: got %0d expected 8", fail_cnt);
        end
        checks++;
        if (bus.tries_left !== 4'd2 || bus.display_code !== 24'hFFFFFF) begin
            failures++;
            $display("[TB] FAIL fail1_idle: got %0d/%h expected 2/%h", bus.tries_left, bus.display_code, 24'hFFFFFF);
        end
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        @(negedge clk);
        checks++;
        if (bus.display_code !== 24'hFFFFF1) begin
            failures++;
            $display("[TB] FAIL fail2_display: got %h expected %h", bus.display_code, 24'hFFFFF1);
        end
        repeat (10) @(negedge clk);
        press(4'd0); press(4'd0); press(4'd0); press(4'd0);
        fail_cnt = 0;
        lock_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.display_code === 24'hFFFFF0 && bus.tries_left === 4'd0) fail_cnt++;
            if (bus.locked_out === 1'b1 && bus.display_code === 24'h888888) lock_cnt++;
        end
        checks++;
        if (fail_cnt != 8) begin
            failures++;
            $display("[TB] FAIL fail3_len: got %0d expected 8", fail_cnt);
        end
        checks++;
        if (lock_cnt != 8) begin
            failures++;
            $display("[TB] FAIL lockout_len: got %0d expected 8", lock_cnt);
        end
        checks++;
        if (bus.tries_left !== 4'd3 || bus.locked_out !== 1'b0 || bus.display_code !== 24'hFFFFFF) begin
            failures++;
            $display("[TB] FAIL lockout_exit: got %0d/%b/%h expected 3/0/%h", bus.tries_left, bus.locked_out, bus.display_code, 24'hFFFFFF);
        end
    endtask

    task automatic test_timeout();
        press(4'd1);
        press(4'd2);
        repeat (7) @(negedge clk);
        checks++;
        if (bus.display_code !== 24'hFFFF12) begin
            failures++;
            $display("[TB] FAIL timeout_last_cycle: got %h expected %h", bus.display_code, 24'hFFFF12);
        end
        @(negedge clk);
        checks++;
        if (bus.display_code !== 24'hFFFFFF || bus.tries_left !== 4'd3) begin
            failures++;
            $display("[TB] FAIL timeout_idle: got %h/%0d expected %h/3", bus.display_code, bus.tries_left, 24'hFFFFFF);
        end
    endtask

    task automatic test_key_wins_timeout();
        press(4'd1);
        repeat (6) @(negedge clk);
        press(4'd2);
        checks++;
        if (bus.display_code !== 24'hFFFF12) begin
            failures++;
            $display("[TB] FAIL key_vs_timeout: got %h expected %h", bus.display_code, 24'hFFFF12);
        end
        press(4'd3);
        press(4'd4);
        @(negedge clk);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL key_vs_timeout_unlock: got %b expected 1", bus.unlocked);
        end
    endtask

    task automatic test_keys_during_open();
        press(4'd5);
        press(4'd6);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.display_code !== 24'hFFFFFF || bus.unlocked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL open_keys_dropped: got %h/%b expected %h/0", bus.display_code, bus.unlocked, 24'hFFFFFF);
        end
        press(4'd7);
        checks++;
        if (bus.display_code !== 24'hFFFFF7) begin
            failures++;
            $display("[TB] FAIL open_keys_not_queued: got %h expected %h", bus.display_code, 24'hFFFFF7);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_invalid_keys();
        press(4'd1);
        press(4'hB);
        checks++;
        if (bus.display_code !== 24'hFFFFF1) begin
            failures++;
            $display("[TB] FAIL invalid_key_ignored: got %h expected %h", bus.display_code, 24'hFFFFF1);
        end
        press(4'd2); press(4'd3); press(4'd4);
        checks++;
        if (bus.display_code !== 24'hFF1234) begin
            failures++;
            $display("[TB] FAIL invalid_key_entry: got %h expected %h", bus.display_code, 24'hFF1234);
        end
        @(negedge clk);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            failures++;
            $display("[TB] FAIL invalid_key_unlock: got %b expected 1", bus.unlocked);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 2; a++) begin
            press(4'd9); press(4'd9); press(4'd9); press(4'd9);
            repeat (12) @(negedge clk);
        end
        press(4'd0); press(4'd0); press(4'd0); press(4'd0);
        repeat (12) @(negedge clk);
        checks++;
        if (bus.locked_out !== 1'b1 || bus.tries_left !== 4'd0) begin
            failures++;
            $display("[TB] FAIL arst_pre_lockout: got %b/%0d expected 1/0", bus.locked_out, bus.tries_left);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.locked_out !== 1'b0 || bus.tries_left !== 4'd3 || bus.display_code !== 24'hFFFFFF || bus.unlocked !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arst_lockout: got %b/%0d/%h/%b expected 0/3/%h/0", bus.locked_out, bus.tries_left, bus.display_code, bus.unlocked, 24'hFFFFFF);
        end
        @(negedge clk);
        rst = 1'b0;
        press(4'd1);
        press(4'd2);
        checks++;
        if (bus.display_code !== 24'hFFFF12) begin
            failures++;
            $display("[TB] FAIL arst_pre_entry: got %h expected %h", bus.display_code, 24'hFFFF12);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.display_code !== 24'hFFFFFF || bus.tries_left !== 4'd3 || bus.unlocked !== 1'b0 || bus.locked_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arst_entry: got %h/%0d/%b/%b expected %h/3/0/0", bus.display_code, bus.tries_left, bus.unlocked, bus.locked_out, 24'hFFFFFF);
        end
        @(negedge clk);
        rst = 1'b0;
        press(4'd3);
        checks++;
        if (bus.display_code !== 24'hFFFFF3) begin
            failures++;
            $display("[TB] FAIL arst_entry_cleared: got %h expected %h", bus.display_code, 24'hFFFFF3);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_timeout();
        test_key_wins_timeout();
        test_keys_during_open();
        test_invalid_keys();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
